// File: rtl/ysyx_25040129_burst_sram_pkg.sv
// Shared AXI read constants and the responder state encoding.
// The instruction cache imports the same RESP/BURST constants.
package ysyx_25040129_burst_sram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LAT  = 2'b01,
        BEAT = 2'b10
    } state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_25040129_burst_addr_gen.sv
// Burst address and beat counter. All outputs describe the beat selected
// after this clock edge, so the beat register can be loaded in the same edge.
module ysyx_25040129_burst_addr_gen
    import ysyx_25040129_burst_sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE      = 32'h8000_0000,
    parameter int          DEPTH_WORD_DIG = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic                      advance_i,
    input  logic [31:0]               araddr_i,
    input  logic [7:0]                arlen_i,
    input  logic [1:0]                arburst_i,
    output logic [DEPTH_WORD_DIG-1:0] word_idx_o,
    output logic                      in_range_o,
    output logic                      last_o,
    output logic                      unsup_o
);

    logic [31:0] addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  len_q, len_d;
    logic [1:0]  burst_q, burst_d;
    logic [31:0] offset;
    logic        unused_offset_lsb;

    always_comb begin
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        burst_d = burst_q;
        if (load_i) begin
            addr_d  = word_align(araddr_i);
            cnt_d   = 8'd0;
            len_d   = arlen_i;
            burst_d = arburst_i;
        end else if (advance_i) begin
            // FIXED bursts re-read the same word; INCR is allowed to wrap at 2^32.
            addr_d = (burst_q == BURST_INCR) ? addr_q + 32'd4 : addr_q;
            cnt_d  = cnt_q + 8'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            burst_q <= BURST_FIXED;
        end else begin
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            burst_q <= burst_d;
        end
    end

    assign offset            = addr_d - ADDR_BASE;
    assign in_range_o        = (offset[31:DEPTH_WORD_DIG+2] == '0);
    assign word_idx_o        = offset[DEPTH_WORD_DIG+1:2];
    assign unused_offset_lsb = ^offset[1:0];
    assign last_o            = (cnt_d == len_d);
    assign unsup_o           = burst_d[1];

endmodule

// File: rtl/ysyx_25040129_burst_sram.sv
// AXI read-channel responder backed by a preloadable word array, with
// programmable first-beat and inter-beat latency for miss-penalty studies.
module ysyx_25040129_burst_sram
    import ysyx_25040129_burst_sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE      = 32'h8000_0000,
    parameter int          DEPTH_WORD_DIG = 12,
    parameter int          FIRST_LAT      = 2,
    parameter int          BEAT_GAP       = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               araddr_i,
    input  logic                      arvalid_i,
    output logic                      arready_o,
    input  logic [7:0]                arlen_i,
    input  logic [1:0]                arburst_i,
    output logic [31:0]               rdata_o,
    output logic [1:0]                rresp_o,
    output logic                      rvalid_o,
    input  logic                      rready_i,
    output logic                      rlast_o,
    input  logic                      pre_wen_i,
    input  logic [DEPTH_WORD_DIG-1:0] pre_waddr_i,
    input  logic [31:0]               pre_wdata_i
);

    localparam logic [3:0] FIRST_LAT_C = 4'(FIRST_LAT);
    localparam logic [3:0] BEAT_GAP_C  = 4'(BEAT_GAP);

    state_e                    state_q, state_d;
    logic [3:0]                lat_q, lat_d;
    logic                      ar_load;
    logic                      advance;
    logic                      load_beat;
    logic [DEPTH_WORD_DIG-1:0] word_idx;
    logic                      in_range;
    logic                      last;
    logic                      unsup;
    logic [31:0]               rdata_q;
    logic [1:0]                rresp_q;
    logic                      rlast_q;
    logic [31:0]               mem [2**DEPTH_WORD_DIG];

    ysyx_25040129_burst_addr_gen #(
        .ADDR_BASE      (ADDR_BASE),
        .DEPTH_WORD_DIG (DEPTH_WORD_DIG)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load_i     (ar_load),
        .advance_i  (advance),
        .araddr_i   (araddr_i),
        .arlen_i    (arlen_i),
        .arburst_i  (arburst_i),
        .word_idx_o (word_idx),
        .in_range_o (in_range),
        .last_o     (last),
        .unsup_o    (unsup)
    );

    // Held low during reset so no address is accepted while the FSM is being cleared.
    assign arready_o = (state_q == IDLE) && !rst;

    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        ar_load   = 1'b0;
        advance   = 1'b0;
        load_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (arvalid_i && arready_o) begin
                    ar_load = 1'b1;
                    if (FIRST_LAT_C == 4'd0) begin
                        load_beat = 1'b1;
                        state_d   = BEAT;
                    end else begin
                        lat_d   = FIRST_LAT_C;
                        state_d = LAT;
                    end
                end
            end
            LAT: begin
                if (lat_q <= 4'd1) begin
                    load_beat = 1'b1;
                    state_d   = BEAT;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            BEAT: begin
                if (rready_i) begin
                    if (rlast_q) begin
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                        if (BEAT_GAP_C == 4'd0) begin
                            load_beat = 1'b1;
                        end else begin
                            lat_d   = BEAT_GAP_C;
                            state_d = LAT;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Beat register: only reloaded on a new beat, so it holds steady through R stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
        end else if (load_beat) begin
            rlast_q <= last;
            if (unsup) begin
                rdata_q <= '0;
                rresp_q <= RESP_SLVERR;
            end else if (!in_range) begin
                rdata_q <= '0;
                rresp_q <= RESP_DECERR;
            end else begin
                rdata_q <= mem[word_idx];
                rresp_q <= RESP_OKAY;
            end
        end
    end

    // NOTE: the array has no reset so it maps onto plain RAM and preloaded contents survive rst.
    always_ff @(posedge clk) begin
        if (pre_wen_i) begin
            mem[pre_waddr_i] <= pre_wdata_i;
        end
    end

    assign rvalid_o = (state_q == BEAT);
    assign rdata_o  = rdata_q;
    assign rresp_o  = rresp_q;
    assign rlast_o  = rlast_q;

endmodule

// File: tb/tb_ysyx_25040129_burst_sram.sv
// Bench for the burst SRAM: vector table, randomized bursts against a
// beat-level reference model, and a mid-burst reset sequence.
module tb_ysyx_25040129_burst_sram;
    import ysyx_25040129_burst_sram_pkg::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DIG   = 12;
    localparam int          DEPTH = 4096;
    localparam int          LAT0  = 2;
    localparam int          GAP0  = 0;
    localparam int          LAT1  = 1;
    localparam int          GAP1  = 1;
    localparam logic [31:0] A0    = 32'hA000_0000;
    localparam logic [31:0] A1    = 32'hA000_0001;
    localparam logic [31:0] A2    = 32'hA000_0002;
    localparam logic [31:0] A3    = 32'hA000_0003;
    localparam logic [31:0] TOPW  = 32'hFFF0_0FFF;

    logic           clk = 1'b0;
    logic           rst;
    logic [31:0]    araddr;
    logic [7:0]     arlen;
    logic [1:0]     arburst;
    logic           pre_wen;
    logic [DIG-1:0] pre_waddr;
    logic [31:0]    pre_wdata;
    logic           arvalid [2];
    logic           rready  [2];
    logic           arready [2];
    logic           rvalid  [2];
    logic           rlast   [2];
    logic [31:0]    rdata   [2];
    logic [1:0]     rresp   [2];

    logic [31:0]    ref_mem [DEPTH];
    int             n_tests = 0;
    int             n_fail  = 0;
    int             tog     = 0;

    always #5 clk = ~clk;

    ysyx_25040129_burst_sram #(
        .ADDR_BASE(BASE), .DEPTH_WORD_DIG(DIG), .FIRST_LAT(LAT0), .BEAT_GAP(GAP0)
    ) u_dut (
        .clk(clk), .rst(rst),
        .araddr_i(araddr), .arvalid_i(arvalid[0]), .arready_o(arready[0]),
        .arlen_i(arlen), .arburst_i(arburst),
        .rdata_o(rdata[0]), .rresp_o(rresp[0]), .rvalid_o(rvalid[0]),
        .rready_i(rready[0]), .rlast_o(rlast[0]),
        .pre_wen_i(pre_wen), .pre_waddr_i(pre_waddr), .pre_wdata_i(pre_wdata)
    );

    ysyx_25040129_burst_sram #(
        .ADDR_BASE(BASE), .DEPTH_WORD_DIG(DIG), .FIRST_LAT(LAT1), .BEAT_GAP(GAP1)
    ) u_dut_gap (
        .clk(clk), .rst(rst),
        .araddr_i(araddr), .arvalid_i(arvalid[1]), .arready_o(arready[1]),
        .arlen_i(arlen), .arburst_i(arburst),
        .rdata_o(rdata[1]), .rresp_o(rresp[1]), .rvalid_o(rvalid[1]),
        .rready_i(rready[1]), .rlast_o(rlast[1]),
        .pre_wen_i(pre_wen), .pre_waddr_i(pre_waddr), .pre_wdata_i(pre_wdata)
    );

    typedef struct {
        int          sel;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          mode;
        logic [31:0] d0;
        logic [1:0]  r0;
        logic [31:0] dn;
        logic [1:0]  rn;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: beat i of a burst from the address/burst/len rules alone.
    function automatic void model_beat(input logic [31:0] a0, input logic [1:0] burst,
                                       input int i, input int len,
                                       output logic [31:0] d, output logic [1:0] r,
                                       output logic l);
        logic [31:0] a;
        a = {a0[31:2], 2'b00};
        if (burst == BURST_INCR) a = a + 32'(4 * i);
        l = (i == len);
        if (burst[1]) begin
            r = RESP_SLVERR;
            d = '0;
        end else if (a >= BASE && a < BASE + 32'(4 * DEPTH)) begin
            r = RESP_OKAY;
            d = ref_mem[(a - BASE) >> 2];
        end else begin
            r = RESP_DECERR;
            d = '0;
        end
    endfunction

    function automatic logic pick_ready(input int mode);
        logic rr;
        if (mode == 0) begin
            rr = 1'b1;
        end else if (mode == 1) begin
            rr = (tog % 3 == 0);
            tog++;
        end else begin
            rr = 1'($urandom_range(0, 1));
        end
        return rr;
    endfunction

    task automatic run_burst(input int sel, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input int mode,
                             output logic [31:0] d0, output logic [1:0] r0,
                             output logic [31:0] dn, output logic [1:0] rn);
        int          lat, gap, w, beats, stalls;
        logic [31:0] ed;
        logic [1:0]  er;
        logic        el;
        logic        rr;
        lat   = (sel == 0) ? LAT0 : LAT1;
        gap   = (sel == 0) ? GAP0 : GAP1;
        d0    = '0; r0 = '0; dn = '0; rn = '0;
        beats = 0;
        tog   = 0;
        araddr       = addr;
        arlen        = len;
        arburst      = burst;
        arvalid[sel] = 1'b1;
        w = 0;
        while (!arready[sel] && w < 50) begin
            step();
            w++;
        end
        check("arready_idle", 32'(arready[sel]), 32'd1);
        step();
        arvalid[sel] = 1'b0;
        w = 0;
        while (!rvalid[sel] && w < 50) begin
            check("arready_low_lat", 32'(arready[sel]), 32'd0);
            step();
            w++;
        end
        check("first_latency", 32'(w), 32'(lat));
        for (int i = 0; i <= int'(len); i++) begin
            if (!rvalid[sel]) begin
                check("beat_present", 32'(rvalid[sel]), 32'd1);
                break;
            end
            model_beat(addr, burst, i, int'(len), ed, er, el);
            check("rdata", rdata[sel], ed);
            check("rresp", 32'(rresp[sel]), 32'(er));
            check("rlast", 32'(rlast[sel]), 32'(el));
            if (i == 0) begin
                d0 = rdata[sel];
                r0 = rresp[sel];
            end
            dn = rdata[sel];
            rn = rresp[sel];
            stalls = 0;
            rr = pick_ready(mode);
            while (!rr && stalls < 8) begin
                rready[sel] = 1'b0;
                step();
                check("hold_valid", 32'(rvalid[sel]), 32'd1);
                check("hold_rdata", rdata[sel], ed);
                check("hold_rresp", 32'(rresp[sel]), 32'(er));
                check("hold_rlast", 32'(rlast[sel]), 32'(el));
                check("arready_low_stall", 32'(arready[sel]), 32'd0);
                stalls++;
                rr = pick_ready(mode);
            end
            rready[sel] = 1'b1;
            step();
            rready[sel] = 1'b0;
            beats++;
            if (i == int'(len)) begin
                check("arready_after_last", 32'(arready[sel]), 32'd1);
                check("rvalid_after_last", 32'(rvalid[sel]), 32'd0);
            end else begin
                w = 0;
                while (!rvalid[sel] && w < 50) begin
                    check("arready_low_gap", 32'(arready[sel]), 32'd0);
                    step();
                    w++;
                end
                check("beat_gap", 32'(w), 32'(gap));
            end
        end
        check("beat_count", 32'(beats), 32'(int'(len) + 1));
    endtask

    initial begin
        logic [31:0] d0, dn, wd, ra;
        logic [1:0]  r0, rn, rb;
        int          k;

        rst        = 1'b1;
        arvalid[0] = 1'b0; arvalid[1] = 1'b0;
        rready[0]  = 1'b0; rready[1]  = 1'b0;
        araddr     = '0; arlen = '0; arburst = BURST_INCR;
        pre_wen    = 1'b0; pre_waddr = '0; pre_wdata = '0;
        repeat (3) step();
        check("rst_arready", 32'(arready[0]), 32'd0);
        check("rst_rvalid", 32'(rvalid[0]), 32'd0);
        check("rst_rlast", 32'(rlast[0]), 32'd0);
        check("rst_rresp", 32'(rresp[0]), 32'(RESP_OKAY));
        check("rst_rdata", rdata[0], 32'd0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            if (i < 4) wd = A0 + 32'(i);
            else if (i == DEPTH - 1) wd = TOPW;
            else wd = $urandom;
            ref_mem[i] = wd;
            pre_wen    = 1'b1;
            pre_waddr  = DIG'(i);
            pre_wdata  = wd;
            step();
        end
        pre_wen = 1'b0;

        vecs[0] = '{0, 32'h8000_0000, 8'd3, BURST_INCR,  0, A0,   RESP_OKAY,   A3,    RESP_OKAY};
        vecs[1] = '{0, 32'h8000_0000, 8'd3, BURST_INCR,  1, A0,   RESP_OKAY,   A3,    RESP_OKAY};
        vecs[2] = '{1, 32'h8000_0008, 8'd2, BURST_FIXED, 0, A2,   RESP_OKAY,   A2,    RESP_OKAY};
        vecs[3] = '{0, 32'h8000_3FFC, 8'd1, BURST_INCR,  0, TOPW, RESP_OKAY,   32'd0, RESP_DECERR};
        vecs[4] = '{0, 32'h8000_0000, 8'd1, 2'b10,       2, 32'd0, RESP_SLVERR, 32'd0, RESP_SLVERR};
        vecs[5] = '{1, 32'h8000_0007, 8'd0, BURST_INCR,  0, A1,   RESP_OKAY,   A1,    RESP_OKAY};
        vecs[6] = '{0, 32'h7FFF_FFFC, 8'd1, BURST_INCR,  0, 32'd0, RESP_DECERR, A0,    RESP_OKAY};
        vecs[7] = '{1, 32'hFFFF_FFFC, 8'd1, 2'b11,       2, 32'd0, RESP_SLVERR, 32'd0, RESP_SLVERR};

        foreach (vecs[v]) begin
            run_burst(vecs[v].sel, vecs[v].addr, vecs[v].len, vecs[v].burst, vecs[v].mode,
                      d0, r0, dn, rn);
            check($sformatf("vec%0d_first_data", v), d0, vecs[v].d0);
            check($sformatf("vec%0d_first_resp", v), 32'(r0), 32'(vecs[v].r0));
            check($sformatf("vec%0d_last_data", v), dn, vecs[v].dn);
            check($sformatf("vec%0d_last_resp", v), 32'(rn), 32'(vecs[v].rn));
        end

        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, DEPTH - 1);
            wd = $urandom;
            ref_mem[k] = wd;
            pre_wen = 1'b1; pre_waddr = DIG'(k); pre_wdata = wd;
            step();
            pre_wen = 1'b0;
            case ($urandom_range(0, 3))
                0:       ra = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
                1:       ra = BASE + 32'(4 * DEPTH) - 32'(4 * $urandom_range(1, 4));
                2:       ra = $urandom;
                default: ra = BASE - 32'(4 * $urandom_range(1, 4));
            endcase
            rb = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            run_burst($urandom_range(0, 1), ra, 8'($urandom_range(0, 7)), rb, 2, d0, r0, dn, rn);
        end

        // Reset after the first beat of a 4-beat burst.
        araddr = BASE; arlen = 8'd3; arburst = BURST_INCR; arvalid[0] = 1'b1;
        step();
        arvalid[0] = 1'b0;
        k = 0;
        while (!rvalid[0] && k < 50) begin
            step();
            k++;
        end
        check("mid_rst_beat0", rdata[0], A0);
        rready[0] = 1'b1;
        step();
        check("mid_rst_beat1_valid", 32'(rvalid[0]), 32'd1);
        rready[0] = 1'b0;
        rst = 1'b1;
        step();
        check("mid_rst_rvalid", 32'(rvalid[0]), 32'd0);
        check("mid_rst_rlast", 32'(rlast[0]), 32'd0);
        check("mid_rst_arready", 32'(arready[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_arready", 32'(arready[0]), 32'd1);
        step();
        check("post_rst_no_beat", 32'(rvalid[0]), 32'd0);
        run_burst(0, BASE + 32'd12, 8'd0, BURST_INCR, 0, d0, r0, dn, rn);
        check("post_rst_data", d0, A3);
        check("post_rst_resp", 32'(r0), 32'(RESP_OKAY));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
